seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Run-time configurable serial pattern detector. A PAT_W-bit
//               history register collects valid input bits; when the newest
//               len bits equal the active pattern a registered match pulse
//               is produced and a saturating match counter advances.
//               Overlapping or non-overlapping matching is selectable.
// Ports       : clk          - sole clock, rising edge
//               reset        - synchronous active-high reset
//               din          - serial data bit
//               din_valid    - din qualifier
//               cfg_load     - one-cycle request to load a new configuration
//               cfg_pattern  - new pattern (bit cfg_len-1 oldest, bit 0 newest)
//               cfg_len      - new pattern length (1..PAT_W)
//               cfg_overlap  - 1 = overlapping matches
//               cnt_clr      - synchronous clear of match_count
//               y            - registered match pulse
//               match_count  - saturating match counter
//               armed        - history holds at least len-1 valid bits
//               cfg_err      - pulse after a rejected cfg_load
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int               PAT_W       = 8,
    parameter int               LEN_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'b0000_0101),
    parameter logic [LEN_W-1:0] DEF_LEN     = LEN_W'(4),
    parameter logic             DEF_OVERLAP = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             din,
    input  wire logic             din_valid,
    input  wire logic             cfg_load,
    input  wire logic [PAT_W-1:0] cfg_pattern,
    input  wire logic [LEN_W-1:0] cfg_len,
    input  wire logic             cfg_overlap,
    input  wire logic             cnt_clr,
    output logic                  y,
    output logic [CNT_W-1:0]      match_count,
    output logic                  armed,
    output logic                  cfg_err
);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    localparam logic [LEN_W:0] c_MAX_LEN   = (LEN_W+1)'(PAT_W);
    // A one-bit pattern needs no history, so it is armed straight out of reset.
    localparam state_t         c_RST_STATE = (DEF_LEN == LEN_W'(1)) ? S_ARMED : S_FILL;

    state_t             r_state,   w_state_nxt;
    logic [PAT_W-1:0]   r_pattern, w_pattern_nxt;
    logic [LEN_W-1:0]   r_len,     w_len_nxt;
    logic               r_overlap, w_overlap_nxt;
    logic [PAT_W-1:0]   r_hist,    w_hist_nxt;
    logic [LEN_W-1:0]   r_fill,    w_fill_nxt;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic               r_y;
    logic               r_cfg_err, w_cfg_err_nxt;

    logic [PAT_W-1:0]   w_window;
    logic [PAT_W-1:0]   w_mask;
    logic               w_match;
    logic               w_cfg_ok;

    // Window seen by the comparator: stored history plus the bit arriving now.
    assign w_window = {r_hist[PAT_W-2:0], din};
    assign w_cfg_ok = (cfg_len != '0) && ({1'b0, cfg_len} <= c_MAX_LEN);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // A configuration load in the same cycle discards the incoming bit.
    assign w_match = din_valid && !cfg_load && (r_state == S_ARMED) &&
                     (((w_window ^ r_pattern) & w_mask) == '0);

    always_comb begin
        w_pattern_nxt = r_pattern;
        w_len_nxt     = r_len;
        w_overlap_nxt = r_overlap;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_cfg_err_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;

        if (cfg_load) begin
            if (w_cfg_ok) begin
                w_pattern_nxt = cfg_pattern;
                w_len_nxt     = cfg_len;
                w_overlap_nxt = cfg_overlap;
                w_hist_nxt    = '0;
                w_fill_nxt    = '0;
            end else begin
                w_cfg_err_nxt = 1'b1;
            end
        end else if (din_valid) begin
            w_hist_nxt = w_window;
            if (w_match && !r_overlap) begin
                // The matching bit must not contribute to the next match.
                w_fill_nxt = '0;
            end else if (r_fill != r_len) begin
                w_fill_nxt = r_fill + LEN_W'(1);
            end
        end

        // ARMED once one more bit would complete a full-length window.
        if (({1'b0, w_fill_nxt} + (LEN_W+1)'(1)) >= {1'b0, w_len_nxt}) begin
            w_state_nxt = S_ARMED;
        end else begin
            w_state_nxt = S_FILL;
        end

        if (cnt_clr) begin
            w_cnt_nxt = w_match ? CNT_W'(1) : '0;
        end else if (w_match && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_RST_STATE;
            r_pattern <= DEF_PATTERN;
            r_len     <= DEF_LEN;
            r_overlap <= DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_y       <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_len     <= w_len_nxt;
            r_overlap <= w_overlap_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_match;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign y           = r_y;
    assign match_count = r_cnt;
    assign armed       = (r_state == S_ARMED);
    assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire
